// File: rtl/shift_exec_ctrl.sv
// shift_exec_ctrl: one-bit-per-clock LSL/LSR/ASR sequencer with N/Z/C flags.
// Requests and responses use valid/ready handshakes; abort kills the op in flight.
module shift_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_s,
  input  logic [1:0]        req_stype,
  input  logic [DATA_W-1:0] req_rm,
  input  logic [AMT_W-1:0]  req_amount,
  input  logic [2:0]        req_flags,
  input  logic              abort,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rd,
  output logic [2:0]        rsp_flags,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0] cnt, cap;
  logic [1:0] stype;
  logic s, c;
  logic [2:0] flags;
  // DATA_W+1 iterations already shift out every bit, so larger amounts saturate there
  assign cap = (32'(req_amount) > DATA_W + 1) ? CW'(DATA_W + 1) : CW'(req_amount);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      stype <= '0;
      s     <= 1'b0;
      flags <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          sreg  <= req_rm;
          cnt   <= cap;
          c     <= req_flags[0];
          stype <= req_stype;
          s     <= req_s;
          flags <= req_flags;
          state <= (cap == '0 || req_stype == 2'b11) ? DONE : SHIFT;
        end
        SHIFT: if (abort) state <= IDLE;
        else begin
          c     <= (stype == 2'b00) ? sreg[DATA_W-1] : sreg[0];
          // ASR keeps the sign bit in place, so the MSB is the captured rm[MSB]
          sreg  <= (stype == 2'b00) ? {sreg[DATA_W-2:0], 1'b0}
                                    : {(stype == 2'b10) & sreg[DATA_W-1], sreg[DATA_W-1:1]};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: if (abort || rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign busy      = state != IDLE;
  assign rsp_rd    = sreg;
  assign rsp_flags = s ? {sreg[DATA_W-1], ~|sreg, c} : flags;
endmodule

// File: tb/tb_shift_exec_ctrl.sv
// tb_shift_exec_ctrl: scoreboard bench for shift_exec_ctrl covering the
// directed vectors, backpressure, abort, async reset and random requests.
module tb_shift_exec_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_s = 0;
  logic [1:0] req_stype = 0;
  logic [31:0] req_rm = 0;
  logic [7:0] req_amount = 0;
  logic [2:0] req_flags = 0;
  logic abort = 0, rsp_valid, rsp_ready = 0, busy;
  logic [31:0] rsp_rd;
  logic [2:0] rsp_flags;
  int pass = 0, total = 0;

  typedef struct {logic [31:0] rd; logic [2:0] fl; int lat;} exp_t;
  exp_t q[$];

  shift_exec_ctrl #(.DATA_W(32), .AMT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_stype(req_stype), .req_rm(req_rm), .req_amount(req_amount),
    .req_flags(req_flags), .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] st, input logic sb, input logic [31:0] rm,
                                 input logic [7:0] amt, input logic [2:0] fl);
    exp_t m;
    int n;
    logic [31:0] rd;
    logic c;
    n = (amt > 33) ? 33 : int'(amt);
    rd = rm;
    c = fl[0];
    if (n != 0 && st != 2'b11) begin
      if (st == 2'b00) begin
        rd = (n >= 32) ? 32'h0 : rm << n;
        c  = (n <= 32) ? rm[32-n] : 1'b0;
      end else if (st == 2'b01) begin
        rd = (n >= 32) ? 32'h0 : rm >> n;
        c  = (n <= 32) ? rm[n-1] : 1'b0;
      end else begin
        rd = (n >= 32) ? {32{rm[31]}} : 32'($signed(rm) >>> n);
        c  = (n <= 32) ? rm[n-1] : rm[31];
      end
    end
    m.rd = rd;
    m.fl = sb ? {rd[31], rd == 32'h0, c} : fl;
    m.lat = 1 + ((st == 2'b11) ? 0 : n);
    return m;
  endfunction

  task automatic run(input logic [1:0] st, input logic sb, input logic [31:0] rm, input logic [7:0] amt,
                     input logic [2:0] fl, input exp_t e, input int hold, input logic ab);
    exp_t g;
    int lat;
    q.push_back(e);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL req_ready_idle got=%b exp=1", req_ready); else pass++;
    req_valid = 1; req_stype = st; req_s = sb; req_rm = rm; req_amount = amt; req_flags = fl; abort = ab;
    @(negedge clk);
    req_valid = 0; abort = 0; req_rm = $urandom; req_amount = 8'($urandom); req_flags = 3'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    g = q.pop_front();
    total++; if (rsp_valid !== 1'b1) $display("FAIL rsp_timeout got=%b exp=1", rsp_valid); else pass++;
    total++; if (rsp_rd !== g.rd) $display("FAIL rsp_rd got=%h exp=%h", rsp_rd, g.rd); else pass++;
    total++; if (rsp_flags !== g.fl) $display("FAIL rsp_flags got=%b exp=%b", rsp_flags, g.fl); else pass++;
    total++; if (lat !== g.lat) $display("FAIL latency got=%0d exp=%0d", lat, g.lat); else pass++;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rd !== g.rd || rsp_flags !== g.fl || req_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL hold_stable got=%b/%h/%b/%b/%b exp=1/%h/%b/0/1",
                 rsp_valid, rsp_rd, rsp_flags, req_ready, busy, g.rd, g.fl);
      else pass++;
    end
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL handshake_idle got=%b/%b/%b exp=0/1/0", rsp_valid, req_ready, busy);
    else pass++;
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic [2:0] fl, input int lat);
    exp_t m;
    m.rd = rd; m.fl = fl; m.lat = lat;
    return m;
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rd !== 32'h0 || rsp_flags !== 3'b000)
      $display("FAIL reset_outputs got=%b/%b/%h/%b exp=0/0/0/000", rsp_valid, busy, rsp_rd, rsp_flags);
    else pass++;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else pass++;
  endtask

  task automatic test_directed();
    run(2'b00, 1, 32'h8000_0001, 1,   3'b000, mk(32'h0000_0002, 3'b001, 2),  0, 0);
    run(2'b10, 1, 32'h8000_0000, 4,   3'b000, mk(32'hF800_0000, 3'b100, 5),  0, 0);
    run(2'b10, 1, 32'h8000_0000, 200, 3'b000, mk(32'hFFFF_FFFF, 3'b101, 34), 0, 0);
    run(2'b01, 1, 32'h8000_0000, 32,  3'b000, mk(32'h0,         3'b011, 33), 0, 0);
    run(2'b01, 1, 32'h8000_0000, 33,  3'b000, mk(32'h0,         3'b010, 34), 0, 0);
    run(2'b00, 1, 32'h0000_0001, 32,  3'b000, mk(32'h0,         3'b011, 33), 0, 0);
    run(2'b00, 1, 32'h0000_0000, 0,   3'b001, mk(32'h0,         3'b011, 1),  0, 0);
    run(2'b00, 0, 32'h0000_0000, 0,   3'b101, mk(32'h0,         3'b101, 1),  0, 0);
    run(2'b11, 1, 32'h8000_0004, 7,   3'b000, mk(32'h8000_0004, 3'b100, 1),  0, 0);
    run(2'b01, 0, 32'hF0F0_F0F0, 4,   3'b010, mk(32'h0F0F_0F0F, 3'b010, 5),  0, 0);
  endtask

  task automatic test_backpressure();
    run(2'b01, 1, 32'h0000_00F0, 3, 3'b000, mk(32'h0000_001E, 3'b000, 4), 5, 0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    req_valid = 1; req_stype = 2'b00; req_s = 1; req_rm = 32'h1234_5678; req_amount = 10; req_flags = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk); @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_shift got=%b/%b/%b exp=0/1/0", rsp_valid, req_ready, busy);
    else pass++;
    repeat (12) @(negedge clk);
    total++; if (rsp_valid !== 1'b0) $display("FAIL abort_no_rsp got=%b exp=0", rsp_valid); else pass++;
    run(2'b00, 1, 32'h0000_0003, 2, 3'b000, mk(32'h0000_000C, 3'b000, 3), 0, 1);
    @(negedge clk);
    req_valid = 1; req_stype = 2'b11; req_s = 0; req_amount = 0;
    @(negedge clk);
    req_valid = 0; abort = 1; rsp_ready = 1;
    @(negedge clk);
    abort = 0; rsp_ready = 0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL abort_done got=%b/%b exp=0/1", rsp_valid, req_ready);
    else pass++;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    req_valid = 1; req_stype = 2'b10; req_s = 1; req_rm = 32'h8765_4321; req_amount = 20; req_flags = 3'b111;
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rd !== 32'h0 || rsp_flags !== 3'b000)
      $display("FAIL rst_mid got=%b/%b/%h/%b exp=0/0/0/000", rsp_valid, busy, rsp_rd, rsp_flags);
    else pass++;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready got=%b exp=1", req_ready); else pass++;
  endtask

  task automatic test_random();
    logic [1:0] st;
    logic sb;
    logic [31:0] rm;
    logic [7:0] amt;
    logic [2:0] fl;
    for (int i = 0; i < 20; i++) begin
      st = 2'($urandom); sb = 1'($urandom); rm = $urandom; fl = 3'($urandom);
      amt = (i % 5 == 4) ? 8'($urandom) : 8'($urandom_range(0, 34));
      run(st, sb, rm, amt, fl, model(st, sb, rm, amt, fl), i % 3, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/shift_exec_ctrl.md
Name: shift_exec_ctrl

Overview:
Multi-cycle sequencer for the MOV / logical / arithmetic shift datapath. It accepts one shift request over a valid/ready handshake, shifts the operand one bit per clock under a state machine, and computes the result and the N/Z/C flags. It returns the result over a second valid/ready handshake. It sits between instruction decode (op 4'b1101) and register-file writeback / flag update.

Parameters:
DATA_W, 32, operand/result width
AMT_W, 8, shift-amount width (operand2 field)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept request (IDLE only)
req_s  input  1  S bit: update flags
req_stype  input  2  00 LSL, 01 LSR, 10 ASR, 11 reserved (MOV)
req_rm  input  DATA_W  source operand Rm
req_amount  input  AMT_W  shift amount
req_flags  input  3  incoming {N,Z,C}
abort  input  1  synchronous kill of in-flight op
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_rd  output  DATA_W  result Rd
rsp_flags  output  3  outgoing {N,Z,C}
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1 once rst deasserts; rsp_valid=0, rsp_rd=0, rsp_flags=0, busy=0; internal shift reg, count and carry cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: req_ready=1. Accept on req_valid&req_ready. Capture rm, stype, s, flags, and count = min(amount, DATA_W+1).
  - If count=0 or stype=11: go to DONE. Result = rm; C keeps captured value.
  - Otherwise go to SHIFT.
- SHIFT: one bit per cycle; count decrements.
  - LSL: C <= reg[MSB]; reg <= reg<<1.
  - LSR: C <= reg[0]; reg <= reg>>1, zero fill.
  - ASR: C <= reg[0]; reg <= reg>>1, fill with captured rm[MSB].
  - C is the last bit shifted out, not an OR of all shifted bits.
  - When count reaches 1 in the current cycle, next state is DONE.
- Amount > DATA_W: capped at DATA_W+1 iterations. This gives LSL/LSR result 0, C=0; ASR result all sign bits, C=rm[MSB]. Amount = DATA_W gives LSL C=rm[0], LSR C=rm[MSB].
- DONE: rsp_valid=1. rsp_rd and rsp_flags are held stable until rsp_valid&rsp_ready, then go to IDLE. req_ready=0 throughout, so there is no request overlap.
- Latency: accept in cycle T → rsp_valid from cycle T+1+count. Minimum 1 cycle, maximum DATA_W+2.
- Flags:
  - s=1: N=rd[MSB], Z=(rd==0), C as computed (captured C when count=0 or stype=11).
  - s=0: rsp_flags = captured req_flags unchanged.
  - stype=11 with s=1: N/Z from rm, C unchanged.
- abort: in SHIFT or DONE, the next state is IDLE and rsp_valid drops. No response is delivered.
  - abort in IDLE is ignored and does not block an accept in the same cycle.
  - abort and rsp_ready together in DONE: treated as abort (no handshake counted).
- Request inputs are ignored outside IDLE. rsp_ready is ignored outside DONE.
- rsp_rd and rsp_flags are don't-care when rsp_valid=0 but must not change while rsp_valid=1.
- rst mid-operation: immediate return to reset values; no response.

Test Plan:
- LSL, rm=0x8000_0001, amount=1, s=1, flags=000 → rsp_rd=0x0000_0002, flags {N,Z,C}=001, rsp_valid at accept+2.
- ASR, rm=0x8000_0000, amount=4, s=1 → rd=0xF800_0000, flags=100, rsp_valid at accept+5. Same with amount=200 → rd=0xFFFF_FFFF, flags=101, rsp_valid at accept+34.
- LSR, rm=0x8000_0000: amount=32, s=1 → rd=0, flags=011. Amount=33 → rd=0, flags=010.
- MOV path, amount=0, rm=0x0000_0000, s=1, flags=001 → rd=0, flags=011, rsp_valid at accept+1. Repeat with s=0, flags=101 → rsp_flags=101.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_rd/rsp_flags stable, req_ready=0, busy=1. rsp_ready=1 → IDLE next cycle, req_ready=1.
- Abort at SHIFT cycle 3 of LSL by 10 → no rsp_valid, IDLE next cycle. New request accepted immediately. Async rst pulse mid-SHIFT → all outputs at reset values within the same cycle.
